// File: rtl/disc_drop_if.sv
// Drawer handshake between the disc-drop controller and the object drawer.
// The controller (master) presents an object origin and colour and holds
// draw_req high. The drawer (slave) answers with a single-cycle draw_done
// pulse once the object is fully plotted.
//   obj_x     [7:0]  object origin x
//   obj_y     [6:0]  object origin y
//   obj_color [2:0]  object colour (3'b000 erases)
//   draw_req         level request, held until draw_done
//   draw_done        single-cycle completion pulse from the drawer
interface disc_drop_if;
    logic [7:0] obj_x;
    logic [6:0] obj_y;
    logic [2:0] obj_color;
    logic       draw_req;
    logic       draw_done;

    modport master (
        output obj_x, obj_y, obj_color, draw_req,
        input  draw_done
    );

    modport slave (
        input  obj_x, obj_y, obj_color, draw_req,
        output draw_done
    );
endinterface

// File: rtl/disc_drop_ctrl.sv
// Disc-drop controller for a 7x6 connect-four board. It accepts a column
// request, rejects it if the column is invalid or full, and otherwise
// animates the disc falling from the top row: draw, dwell, erase, move one
// row down, and repeat until the landing row. The landing draw is left on
// screen and the move is committed.
//   CLOCK_50    system clock, rising edge
//   Resetn      synchronous active-low reset
//   col_sel     requested column (0..6 valid)
//   drop        single-cycle drop request
//   draw        drawer handshake (obj_x/obj_y/obj_color/draw_req/draw_done)
//   player      side to move: 0 = red, 1 = yellow
//   busy        high whenever the controller is not idle
//   illegal     one-cycle pulse on a rejected drop
//   board_full  high once all 42 discs are committed
//
// state      | meaning
// IDLE       | waiting for a drop request
// CHECK      | validate column, set up the fall
// DRAW       | request disc drawn at the current row
// DRAW_WAIT  | wait for drawer; landed -> COMMIT, else -> HOLD
// HOLD       | dwell STEP_CYCLES cycles with the disc visible
// ERASE      | request the current row cleared
// ERASE_WAIT | wait for drawer, then move one row down
// COMMIT     | bump column height and disc count, swap player
module disc_drop_ctrl #(
    parameter int STEP_CYCLES = 2500000,
    parameter int X0          = 24,
    parameter int Y0          = 16
) (
    input  logic        CLOCK_50,
    input  logic        Resetn,
    input  logic [2:0]  col_sel,
    input  logic        drop,
    disc_drop_if.master draw,
    output logic        player,
    output logic        busy,
    output logic        illegal,
    output logic        board_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DRAW,
        S_DRAW_WAIT,
        S_HOLD,
        S_ERASE,
        S_ERASE_WAIT,
        S_COMMIT
    } state_t;

    localparam int           CW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(STEP_CYCLES - 1);

    state_t        state, state_nxt;
    logic [2:0]    col_r;
    logic [2:0]    row_r;
    logic [2:0]    target;
    logic [5:0]    total;
    logic          player_r;
    logic [CW-1:0] hold_cnt;
    // Entry 7 is never committed; it keeps a lookup with col_r=7 in range.
    logic [2:0]    height [8];

    logic [2:0]    cur_height;
    logic          legal;
    logic          drawing;

    assign cur_height = height[col_r];
    assign legal      = (col_r != 3'd7) && (cur_height != 3'd6);

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            col_r    <= '0;
            row_r    <= '0;
            target   <= '0;
            total    <= '0;
            player_r <= 1'b0;
            hold_cnt <= HOLD_LOAD;
            for (int i = 0; i < 8; i++) begin
                height[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (drop) col_r <= col_sel;
                end
                S_CHECK: begin
                    if (legal) begin
                        row_r  <= 3'd5;
                        target <= cur_height;
                    end
                end
                S_ERASE_WAIT: begin
                    if (draw.draw_done) row_r <= row_r - 3'd1;
                end
                S_COMMIT: begin
                    height[col_r] <= cur_height + 3'd1;
                    total         <= total + 6'd1;
                    player_r      <= ~player_r;
                end
                default: ;
            endcase
            // Dwell timer reloads outside HOLD so every HOLD visit starts fresh.
            if (state == S_HOLD) hold_cnt <= hold_cnt - CW'(1);
            else                 hold_cnt <= HOLD_LOAD;
        end
    end

    always_comb begin
        state_nxt = state;
        illegal   = 1'b0;
        case (state)
            S_IDLE:       if (drop) state_nxt = S_CHECK;
            S_CHECK: begin
                if (legal) begin
                    state_nxt = S_DRAW;
                end else begin
                    illegal   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DRAW:       state_nxt = S_DRAW_WAIT;
            S_DRAW_WAIT: begin
                if (draw.draw_done) state_nxt = (row_r == target) ? S_COMMIT : S_HOLD;
            end
            S_HOLD:       if (hold_cnt == '0) state_nxt = S_ERASE;
            S_ERASE:      state_nxt = S_ERASE_WAIT;
            S_ERASE_WAIT: if (draw.draw_done) state_nxt = S_DRAW;
            S_COMMIT:     state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    assign drawing = (state == S_DRAW) || (state == S_DRAW_WAIT) ||
                     (state == S_ERASE) || (state == S_ERASE_WAIT);

    // Object fields are forced to zero outside a drawer transaction so the
    // bus is quiet in IDLE and straight out of reset.
    always_comb begin
        draw.draw_req  = drawing;
        draw.obj_x     = '0;
        draw.obj_y     = '0;
        draw.obj_color = '0;
        if (drawing) begin
            draw.obj_x = 8'(X0) + {1'b0, col_r, 4'b0000};
            draw.obj_y = 7'(Y0) + {3'd5 - row_r, 4'b0000};
            if ((state == S_DRAW) || (state == S_DRAW_WAIT))
                draw.obj_color = player_r ? 3'b110 : 3'b100;
        end
    end

    assign player     = player_r;
    assign busy       = (state != S_IDLE);
    assign board_full = (total == 6'd42);

endmodule
